// File: rtl/bcd_stopwatch_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_stopwatch_counter
// Brief    : Two-digit BCD stopwatch (00-99) with start/stop, lap and clear
//            buttons, a clock-divided count tick and registered display nibbles.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_stopwatch_counter #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       btn_startstop,
    input  logic       btn_lap,
    input  logic       btn_clear,
    input  logic       up_down,
    output logic [3:0] SN0,
    output logic [3:0] SN1,
    output logic       running,
    output logic       wrap
);

    localparam logic [CNT_W-1:0] c_tick_last = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] c_presc_one = CNT_W'(1);

    localparam int c_nbtn    = 3;
    localparam int c_btn_ss  = 0;
    localparam int c_btn_lap = 1;
    localparam int c_btn_clr = 2;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_LAP     = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Button synchronisers and rising-edge detectors
    // ------------------------------------------------------------------
    logic [c_nbtn-1:0] w_btn_raw;
    logic [c_nbtn-1:0] r_btn_meta;
    logic [c_nbtn-1:0] r_btn_sync;
    logic [c_nbtn-1:0] r_btn_prev;
    logic [c_nbtn-1:0] w_btn_rise;

    assign w_btn_raw = {btn_clear, btn_lap, btn_startstop};

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_btn_meta <= '0;
            r_btn_sync <= '0;
            r_btn_prev <= '0;
        end else begin
            r_btn_meta <= w_btn_raw;
            r_btn_sync <= r_btn_meta;
            r_btn_prev <= r_btn_sync;
        end
    end

    assign w_btn_rise = r_btn_sync & ~r_btn_prev;

    logic w_ev_ss;
    logic w_ev_lap;
    logic w_ev_clr;

    assign w_ev_ss  = w_btn_rise[c_btn_ss];
    assign w_ev_lap = w_btn_rise[c_btn_lap];
    assign w_ev_clr = w_btn_rise[c_btn_clr];

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_presc;
    logic [3:0]       r_ones;
    logic [3:0]       r_tens;
    logic [3:0]       r_lap_ones;
    logic [3:0]       r_lap_tens;
    logic [3:0]       r_sn0;
    logic [3:0]       r_sn1;
    logic             r_running;
    logic             r_wrap;

    logic w_active;
    logic w_tick;

    assign w_active = (r_state != ST_STOPPED);
    assign w_tick   = w_active && (r_presc == c_tick_last);

    // ------------------------------------------------------------------
    // BCD step (up or down) of the live count
    // ------------------------------------------------------------------
    logic [3:0] w_step_ones;
    logic [3:0] w_step_tens;
    logic       w_step_wrap;

    always_comb begin
        w_step_ones = r_ones;
        w_step_tens = r_tens;
        w_step_wrap = 1'b0;
        if (up_down) begin
            if (r_ones == 4'd9) begin
                w_step_ones = 4'd0;
                if (r_tens == 4'd9) begin
                    w_step_tens = 4'd0;
                    w_step_wrap = 1'b1;
                end else begin
                    w_step_tens = r_tens + 4'd1;
                end
            end else begin
                w_step_ones = r_ones + 4'd1;
            end
        end else begin
            if (r_ones == 4'd0) begin
                w_step_ones = 4'd9;
                if (r_tens == 4'd0) begin
                    w_step_tens = 4'd9;
                    w_step_wrap = 1'b1;
                end else begin
                    w_step_tens = r_tens - 4'd1;
                end
            end else begin
                w_step_ones = r_ones - 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state decode: FSM, lap capture, prescaler and count
    // ------------------------------------------------------------------
    state_t           w_state_nxt;
    logic [3:0]       w_lap_ones_nxt;
    logic [3:0]       w_lap_tens_nxt;
    logic [CNT_W-1:0] w_presc_nxt;
    logic [3:0]       w_ones_nxt;
    logic [3:0]       w_tens_nxt;
    logic             w_wrap_nxt;

    always_comb begin
        w_state_nxt    = r_state;
        w_lap_ones_nxt = r_lap_ones;
        w_lap_tens_nxt = r_lap_tens;
        case (r_state)
            ST_STOPPED: begin
                if (w_ev_ss) begin
                    w_state_nxt = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                // A clear keeps the watch running live, so a lap arriving
                // alongside it is dropped rather than freezing a stale count.
                if (w_ev_ss) begin
                    w_state_nxt = ST_STOPPED;
                end else if (w_ev_lap && !w_ev_clr) begin
                    w_state_nxt    = ST_LAP;
                    w_lap_ones_nxt = r_ones;
                    w_lap_tens_nxt = r_tens;
                end
            end
            ST_LAP: begin
                if (w_ev_ss) begin
                    w_state_nxt = ST_STOPPED;
                end else if (w_ev_clr || w_ev_lap) begin
                    w_state_nxt = ST_RUNNING;
                end
            end
            default: begin
                w_state_nxt = ST_STOPPED;
            end
        endcase
    end

    always_comb begin
        w_presc_nxt = r_presc;
        w_ones_nxt  = r_ones;
        w_tens_nxt  = r_tens;
        w_wrap_nxt  = 1'b0;
        if (w_ev_clr) begin
            w_presc_nxt = '0;
            w_ones_nxt  = 4'd0;
            w_tens_nxt  = 4'd0;
        end else if (w_tick) begin
            w_presc_nxt = '0;
            w_ones_nxt  = w_step_ones;
            w_tens_nxt  = w_step_tens;
            w_wrap_nxt  = w_step_wrap;
        end else if (w_active) begin
            w_presc_nxt = r_presc + c_presc_one;
        end
    end

    // Display selection looks at next-cycle values so the outputs can be
    // registered without adding a cycle of latency behind the count.
    logic [3:0] w_sn0_nxt;
    logic [3:0] w_sn1_nxt;

    always_comb begin
        if (w_state_nxt == ST_LAP) begin
            w_sn0_nxt = w_lap_ones_nxt;
            w_sn1_nxt = w_lap_tens_nxt;
        end else begin
            w_sn0_nxt = w_ones_nxt;
            w_sn1_nxt = w_tens_nxt;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state    <= ST_STOPPED;
            r_presc    <= '0;
            r_ones     <= 4'd0;
            r_tens     <= 4'd0;
            r_lap_ones <= 4'd0;
            r_lap_tens <= 4'd0;
            r_sn0      <= 4'd0;
            r_sn1      <= 4'd0;
            r_running  <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_presc    <= w_presc_nxt;
            r_ones     <= w_ones_nxt;
            r_tens     <= w_tens_nxt;
            r_lap_ones <= w_lap_ones_nxt;
            r_lap_tens <= w_lap_tens_nxt;
            r_sn0      <= w_sn0_nxt;
            r_sn1      <= w_sn1_nxt;
            r_running  <= (w_state_nxt != ST_STOPPED);
            r_wrap     <= w_wrap_nxt;
        end
    end

    assign SN0     = r_sn0;
    assign SN1     = r_sn1;
    assign running = r_running;
    assign wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_bcd_stopwatch_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_stopwatch_counter
// Brief    : Directed vector table plus hand sequences for the BCD stopwatch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_stopwatch_counter;

    logic       clk_in;
    logic       rst;
    logic       btn_startstop;
    logic       btn_lap;
    logic       btn_clear;
    logic       up_down;
    logic [3:0] SN0;
    logic [3:0] SN1;
    logic       running;
    logic       wrap;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    bcd_stopwatch_counter #(
        .TICK_DIV(4),
        .CNT_W   (3)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .btn_startstop(btn_startstop),
        .btn_lap      (btn_lap),
        .btn_clear    (btn_clear),
        .up_down      (up_down),
        .SN0          (SN0),
        .SN1          (SN1),
        .running      (running),
        .wrap         (wrap)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Inputs held for n rising edges, then display (tens*10+ones),
    // running and wrap compared 1 time unit after the last edge.
    typedef struct {
        int rst;
        int ss;
        int lap;
        int clr;
        int ud;
        int n;
        int disp;
        int run;
        int wrp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int r, input int s, input int l, input int c, input int u,
                       input int n, input int d, input int rn, input int w);
        vec_t v;
        v.rst = r; v.ss = s; v.lap = l; v.clr = c; v.ud = u;
        v.n = n; v.disp = d; v.run = rn; v.wrp = w;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int r, input int s, input int l, input int c, input int u);
        rst           = (r != 0);
        btn_startstop = (s != 0);
        btn_lap       = (l != 0);
        btn_clear     = (c != 0);
        up_down       = (u != 0);
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    function automatic int disp_val();
        return int'(SN1) * 10 + int'(SN0);
    endfunction

    task automatic chk_all(input string name, input int d, input int rn, input int w);
        chk({name, " display"}, disp_val(), d);
        chk({name, " running"}, int'(running), rn);
        chk({name, " wrap"}, int'(wrap), w);
    endtask

    // Display nibbles must always be legal BCD.
    always @(negedge clk_in) begin
        if (mon_en) begin
            checks++;
            if (SN0 > 4'd9 || SN1 > 4'd9) begin
                errors++;
                $display("FAIL bcd_range: got SN1=%0d SN0=%0d expected both <= 9", SN1, SN0);
            end
        end
    end

    initial begin
        drive(1, 0, 0, 0, 1);

        //  rst ss lap clr ud   n  disp run wrap     edge after
        add(1, 0, 0, 0, 1,   1,   0, 0, 0);   // E0 reset
        add(0, 1, 0, 0, 1,   1,   0, 0, 0);   // E1
        add(0, 0, 0, 0, 1,   1,   0, 0, 0);   // E2
        add(0, 0, 0, 0, 1,   1,   0, 1, 0);   // E3 running
        add(0, 0, 0, 0, 1,   3,   0, 1, 0);   // E6
        add(0, 0, 0, 0, 1,   1,   1, 1, 0);   // E7 first tick
        add(0, 0, 0, 0, 1,   4,   2, 1, 0);   // E11
        add(0, 0, 0, 0, 1,  28,   9, 1, 0);   // E39
        add(0, 0, 0, 0, 1,   4,  10, 1, 0);   // E43 carry
        add(0, 0, 0, 0, 1, 352,  98, 1, 0);   // E395
        add(0, 0, 0, 0, 1,   4,  99, 1, 0);   // E399
        add(0, 0, 0, 0, 1,   3,  99, 1, 0);   // E402
        add(0, 0, 0, 0, 1,   1,   0, 1, 1);   // E403 99->00 wrap
        add(0, 0, 0, 0, 1,   1,   0, 1, 0);   // E404 wrap gone
        add(0, 0, 0, 0, 1,   3,   1, 1, 0);   // E407
        add(0, 0, 0, 0, 0,   4,   0, 1, 0);   // E411 down
        add(0, 0, 0, 0, 0,   3,   0, 1, 0);   // E414
        add(0, 0, 0, 0, 0,   1,  99, 1, 1);   // E415 00->99 wrap
        add(0, 0, 0, 0, 0,   1,  99, 1, 0);   // E416
        add(0, 0, 0, 0, 0,   3,  98, 1, 0);   // E419
        add(0, 0, 0, 1, 1,   1,  98, 1, 0);   // E420 clear pressed
        add(0, 0, 0, 0, 1,   1,  98, 1, 0);   // E421
        add(0, 0, 0, 0, 1,   1,   0, 1, 0);   // E422 cleared
        add(0, 0, 0, 0, 1,  18,   4, 1, 0);   // E440
        add(0, 0, 1, 0, 1,   1,   4, 1, 0);   // E441 lap pressed
        add(0, 0, 0, 0, 1,   1,   5, 1, 0);   // E442
        add(0, 0, 0, 0, 1,   1,   5, 1, 0);   // E443 LAP at 05
        add(0, 0, 0, 0, 1,   8,   5, 1, 0);   // E451 frozen, live 07
        add(0, 0, 0, 0, 1,   1,   5, 1, 0);   // E452
        add(0, 0, 1, 0, 1,   1,   5, 1, 0);   // E453 lap pressed
        add(0, 0, 0, 0, 1,   1,   5, 1, 0);   // E454 live 08
        add(0, 0, 0, 0, 1,   1,   8, 1, 0);   // E455 back to live
        add(0, 0, 0, 0, 1,  15,  12, 1, 0);   // E470
        add(0, 1, 1, 0, 1,   1,  12, 1, 0);   // E471 ss+lap pressed
        add(0, 0, 0, 0, 1,   2,  12, 0, 0);   // E473 stopped
        add(0, 0, 0, 0, 1,   7,  12, 0, 0);   // E480
        add(0, 1, 0, 0, 1,   1,  12, 0, 0);   // E481 ss pressed
        add(0, 0, 0, 0, 1,   2,  12, 1, 0);   // E483 resumed
        add(0, 0, 0, 0, 1,   1,  13, 1, 0);   // E484 residual tick
        add(0, 0, 0, 0, 1,   3,  13, 1, 0);   // E487
        add(0, 0, 0, 0, 1,   1,  14, 1, 0);   // E488
        add(0, 0, 0, 0, 1,  90,  36, 1, 0);   // E578
        add(0, 0, 1, 0, 1,   1,  36, 1, 0);   // E579 lap pressed
        add(0, 0, 0, 0, 1,   1,  37, 1, 0);   // E580
        add(0, 0, 0, 0, 1,   1,  37, 1, 0);   // E581 LAP at 37
        add(0, 0, 0, 0, 1,   3,  37, 1, 0);   // E584 live 38
        add(0, 0, 0, 1, 1,   1,  37, 1, 0);   // E585 clear pressed
        add(0, 0, 0, 0, 1,   1,  37, 1, 0);   // E586
        add(0, 0, 0, 0, 1,   1,   0, 1, 0);   // E587 cleared, RUNNING
        add(0, 0, 0, 0, 1,   3,   0, 1, 0);   // E590
        add(0, 0, 0, 0, 1,   1,   1, 1, 0);   // E591 full period
        add(0, 0, 0, 0, 1,   1,   1, 1, 0);   // E592
        add(1, 0, 0, 0, 1,   1,   0, 0, 0);   // E593 mid-count reset
        add(0, 0, 0, 0, 1,   8,   0, 0, 0);   // E601 stays stopped

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].ss, vecs[i].lap, vecs[i].clr, vecs[i].ud);
            step(vecs[i].n);
            mon_en = 1'b1;
            chk_all($sformatf("vec%0d", i), vecs[i].disp, vecs[i].run, vecs[i].wrp);
        end

        // Held start/stop yields one event only.
        drive(0, 1, 0, 0, 1);
        step(3);
        chk_all("hold_start", 0, 1, 0);        // E604
        step(7);
        chk_all("hold_still_running", 1, 1, 0); // E611
        drive(0, 0, 0, 0, 1);
        step(1);
        chk_all("hold_released", 2, 1, 0);     // E612
        step(8);
        chk_all("pre_stop", 4, 1, 0);          // E620

        // Stop with a partly-used prescaler, then clear+start together.
        drive(0, 1, 0, 0, 1);
        step(1);
        drive(0, 0, 0, 0, 1);
        step(2);
        chk_all("stopped_at_04", 4, 0, 0);     // E623
        step(2);
        chk_all("stopped_hold", 4, 0, 0);      // E625
        drive(0, 1, 0, 1, 1);
        step(1);
        drive(0, 0, 0, 0, 1);
        step(2);
        chk_all("clear_start", 0, 1, 0);       // E628
        step(3);
        chk_all("clear_presc_reset", 0, 1, 0); // E631
        step(1);
        chk_all("clear_first_tick", 1, 1, 0);  // E632

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_stopwatch_counter.md
Name: bcd_stopwatch_counter

Overview:
- Two-digit BCD stopwatch/counter (00-99) that produces the ones and tens nibbles (SN0, SN1) consumed by the two-digit seven-segment display driver.
- Takes raw push-button levels, synchronises them and edge-detects them.
- Divides the board clock into a count tick and runs a start/stop/lap state machine.
- Output nibbles are always valid BCD (0-9).

Parameters:
- TICK_DIV, 50000000, board clock cycles per count tick (1 Hz at 50 MHz); legal range 2 to 2^26.
- CNT_W, 26, prescaler counter width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- clk_in  input  1  board clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_startstop  input  1  raw start/stop button level, asynchronous.
- btn_lap  input  1  raw lap button level, asynchronous.
- btn_clear  input  1  raw clear button level, asynchronous.
- up_down  input  1  count direction: 1 = up, 0 = down; sampled on each tick.
- SN0  output  4  displayed ones digit, BCD.
- SN1  output  4  displayed tens digit, BCD.
- running  output  1  high in RUNNING or LAP.
- wrap  output  1  one-cycle pulse on 99->00 (up) or 00->99 (down).

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=STOPPED; count=00; lap register=00; prescaler=0.
  - SN0=0, SN1=0, running=0, wrap=0.
  - Synchroniser and edge flops cleared.
  - Reset mid-count abandons all state. Reset has priority over everything.
- Button path:
  - Each button passes through a 2-flop synchroniser, then a third flop for rising-edge detect.
  - The edge pulse is 1 cycle wide and is first acted on at the 3rd rising edge after the input goes high.
  - Holding a button produces exactly one event.
- Prescaler:
  - Increments only while state is RUNNING or LAP; holds its value in STOPPED, so resume keeps the fractional period.
  - When it equals TICK_DIV-1, it returns to 0 and tick=1 for that cycle.
- Count update on tick:
  - Up: ones+1. Ones 9 -> 0 with tens+1. 99 -> 00 and wrap=1.
  - Down: ones-1. Ones 0 -> 9 with tens-1. 00 -> 99 and wrap=1.
  - Count, wrap and the SN outputs update on the same edge (1-cycle latency from tick).
- FSM:
  - STOPPED, startstop -> RUNNING.
  - RUNNING, startstop -> STOPPED.
  - RUNNING, lap -> LAP; lap register <= current count on that edge.
  - LAP, lap -> RUNNING.
  - LAP, startstop -> STOPPED.
  - lap in STOPPED is ignored.
- Display:
  - In LAP, SN1:SN0 = lap register; counting continues underneath.
  - In all other states, SN1:SN0 = live count.
- Clear event, honoured in any state:
  - count=00 and prescaler=0; a tick in the same cycle is discarded.
  - LAP -> RUNNING. STOPPED stays STOPPED; RUNNING stays RUNNING.
- Simultaneous events:
  - startstop beats lap; the lap event is dropped.
  - clear combines with startstop: both take effect, e.g. STOPPED+clear+startstop gives RUNNING from 00.
  - clear beats tick.
- Outputs are registered. No combinational path from the button inputs to the outputs.

Test Plan (TICK_DIV=4):
- Reset, then startstop pulse, up_down=1, run 40 cycles -> running=1 three cycles after the press; count advances 1 per 4 cycles; 09 -> 10 carry correct; SN never exceeds 9.
- Preload to 98 by running up; let 2 ticks pass -> 99 then 00; wrap high exactly 1 cycle on the 00 transition; no wrap on other ticks.
- From 01, up_down=0 -> 00 then 99 with a wrap pulse, then 98.
- Running at 05, lap pulse -> display frozen at 05 while the internal count reaches 08. Second lap -> display shows 08 on the next cycle and running stays 1.
- startstop and lap asserted in the same cycle while RUNNING at 12 -> STOPPED, display 12, lap register unchanged. Another startstop -> resumes and the next tick arrives after the remaining prescaler cycles, not a full 4.
- Clear during LAP at count 37 -> RUNNING, display 00, prescaler restarts. rst asserted mid-count for 1 cycle -> all outputs 0 and state STOPPED on the next edge.
